pipeline_stream_downsizer: RTL and testbench

- Valid/ready stream width converter that sits directly downstream of the pipeline skid buffer.
- Accepts one InWidth-bit word per handshake and emits it as Ratio narrower beats of OutWidth bits, least-significant slice first.
- Flags the final beat of each word so narrow consumers (serial links, byte-wide sinks) can find word boundaries.
- Sustains full throughput: a new word is accepted in the same cycle the last beat of the previous word is consumed.

---
 rtl/pipeline_stream_downsizer_if.sv | 24 ++
 rtl/pipeline_stream_downsizer.sv | 85 ++++++++
 tb/tb_pipeline_stream_downsizer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stream_downsizer_if.sv
// Valid/ready bus of the stream downsizer: wide word in, narrow beats out.
// The slave modport is the downsizer's view; the master modport drives it.
interface pipeline_stream_downsizer_if #(
    parameter int InWidth  = 32,
    parameter int OutWidth = 8
);
    logic                valid_i;
    logic [InWidth-1:0]  data_i;
    logic                ready_o;
    logic                ready_i;
    logic                valid_o;
    logic [OutWidth-1:0] data_o;
    logic                last_o;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, last_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/pipeline_stream_downsizer.sv
// Splits each InWidth-bit word into Ratio OutWidth-bit beats, LSB slice first,
// flagging the last beat. A new word can load in the cycle the last beat leaves.
module pipeline_stream_downsizer #(
    parameter int InWidth = 32,
    parameter int Ratio   = 4,
    localparam int OutWidth = (Ratio >= 1) ? InWidth / Ratio : InWidth
) (
    input logic clk_i,
    input logic rst_ni,
    pipeline_stream_downsizer_if.slave bus
);
    localparam int BeatW = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Ratio - 1);

    if (Ratio < 1 || (InWidth % ((Ratio < 1) ? 1 : Ratio)) != 0) begin : g_bad_params
        $error("pipeline_stream_downsizer: Ratio must be >= 1 and divide InWidth");
    end

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e                        state_q, state_d;
    logic [InWidth-1:0]            word_q, word_d;
    logic [BeatW-1:0]              beat_q, beat_d;
    logic                          full_q;
    logic                          en_q;
    logic [Ratio-1:0][OutWidth-1:0] slices;
    logic                          last;
    logic                          in_fire;
    logic                          out_fire;

    assign full_q   = (state_q == FULL);
    assign slices   = word_q;
    assign last     = full_q && (beat_q == LastBeat);
    assign out_fire = full_q && bus.ready_i;

    assign bus.valid_o = full_q;
    assign bus.last_o  = last;
    assign bus.data_o  = slices[beat_q];
    // en_q keeps ready low while in reset and up to the first edge after release.
    assign bus.ready_o = en_q && (!full_q || (out_fire && last));
    assign in_fire     = bus.valid_i && bus.ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            word_q  <= '0;
            beat_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            beat_q  <= beat_d;
            en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        beat_d  = beat_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    word_d  = bus.data_i;
                    beat_d  = '0;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_fire) begin
                    if (!last) begin
                        beat_d = beat_q + BeatW'(1);
                    end else if (in_fire) begin
                        word_d = bus.data_i;
                        beat_d = '0;
                    end else begin
                        beat_d  = '0;
                        state_d = EMPTY;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pipeline_stream_downsizer.sv
// Directed bench: 32->8 downsizer for the main tests, 8->8 (Ratio=1) slice for the last.
module tb_pipeline_stream_downsizer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipeline_stream_downsizer_if #(.InWidth(32), .OutWidth(8)) if4 ();
    pipeline_stream_downsizer_if #(.InWidth(8),  .OutWidth(8)) if1 ();

    pipeline_stream_downsizer #(.InWidth(32), .Ratio(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if4)
    );
    pipeline_stream_downsizer #(.InWidth(8), .Ratio(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1)
    );

    task automatic test_reset();
        if4.valid_i = 1'b1; if4.data_i = 32'hFFFF_FFFF; if4.ready_i = 1'b1;
        if1.valid_i = 1'b0; if1.data_i = 8'h00; if1.ready_i = 1'b1;
        #3;
        n_chk++;
        if (if4.valid_o !== 1'b0 || if4.last_o !== 1'b0 || if4.data_o !== 8'h00 || if4.ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h r=%b expected 0 0 00 0",
                     if4.valid_o, if4.last_o, if4.data_o, if4.ready_o);
        end
        #10;
        n_chk++;
        if (if4.ready_o !== 1'b0 || if4.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after_edge: got r=%b v=%b expected 0 0", if4.ready_o, if4.valid_o);
        end
        @(negedge clk);
        if4.valid_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        n_chk++;
        if (if4.ready_o !== 1'b1 || if4.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_release: got r=%b v=%b expected 1 0", if4.ready_o, if4.valid_o);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        @(negedge clk);
        if4.valid_i = 1'b1; if4.data_i = 32'h4433_2211; if4.ready_i = 1'b1;
        #1;
        n_chk++;
        if (if4.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 1", if4.ready_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if4.valid_i = 1'b0;
            #1;
            n_chk++;
            if (if4.valid_o !== 1'b1 || if4.data_o !== exp[k] || if4.last_o !== (k == 3)) begin
                n_fail++;
                $display("FAIL single_beat%0d: got v=%b d=%h l=%b expected 1 %h %b",
                         k, if4.valid_o, if4.data_o, if4.last_o, exp[k], (k == 3));
            end
        end
        @(negedge clk); #1;
        n_chk++;
        if (if4.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got valid_o=%b expected 0", if4.valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h21, 8'h43, 8'h65, 8'h87};
        @(negedge clk);
        if4.valid_i = 1'b1; if4.data_i = 32'hDDCC_BBAA; if4.ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 3) if4.data_i = 32'h8765_4321;
            if (k == 4) if4.valid_i = 1'b0;
            #1;
            n_chk++;
            if (if4.valid_o !== 1'b1 || if4.data_o !== exp[k] || if4.last_o !== (k == 3 || k == 7)
                || if4.ready_o !== (k == 3 || k == 7)) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b r=%b expected 1 %h %b %b",
                         k, if4.valid_o, if4.data_o, if4.last_o, if4.ready_o,
                         exp[k], (k == 3 || k == 7), (k == 3 || k == 7));
            end
        end
        @(negedge clk); #1;
        n_chk++;
        if (if4.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got valid_o=%b expected 0", if4.valid_o);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [4] = '{8'h22, 8'h22, 8'h33, 8'h44};
        @(negedge clk);
        if4.valid_i = 1'b1; if4.data_i = 32'h4433_2211; if4.ready_i = 1'b1;
        @(negedge clk);
        if4.valid_i = 1'b0;
        #1;
        n_chk++;
        if (if4.data_o !== 8'h11) begin
            n_fail++;
            $display("FAIL stall_beat0: got %h expected 11", if4.data_o);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if4.ready_i = 1'b0;
            if4.valid_i = 1'b1; if4.data_i = 32'hDEAD_DEAD;
            #1;
            n_chk++;
            if (if4.valid_o !== 1'b1 || if4.data_o !== 8'h22 || if4.ready_o !== 1'b0 || if4.last_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b d=%h r=%b l=%b expected 1 22 0 0",
                         c, if4.valid_o, if4.data_o, if4.ready_o, if4.last_o);
            end
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            if4.ready_i = 1'b1; if4.valid_i = 1'b0;
            #1;
            n_chk++;
            if (if4.valid_o !== 1'b1 || if4.data_o !== exp[k] || if4.last_o !== (k == 3)) begin
                n_fail++;
                $display("FAIL stall_resume%0d: got v=%b d=%h l=%b expected 1 %h %b",
                         k, if4.valid_o, if4.data_o, if4.last_o, exp[k], (k == 3));
            end
        end
        @(negedge clk); #1;
        n_chk++;
        if (if4.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: got valid_o=%b expected 0", if4.valid_o);
        end
    endtask

    task automatic test_ready_toggle();
        logic [7:0] exp [4] = '{8'h0F, 8'hF0, 8'hA5, 8'hA5};
        int idx = 0;
        @(negedge clk);
        if4.valid_i = 1'b1; if4.data_i = 32'hA5A5_F00F; if4.ready_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if4.valid_i = 1'b0;
            if4.ready_i = (c % 2 == 0);
            #1;
            if (if4.valid_o && if4.ready_i) begin
                n_chk++;
                if (idx >= 4) begin
                    n_fail++;
                    $display("FAIL toggle_extra: got beat %h after 4 beats expected none", if4.data_o);
                end else if (if4.data_o !== exp[idx] || if4.last_o !== (idx == 3)) begin
                    n_fail++;
                    $display("FAIL toggle_beat%0d: got d=%h l=%b expected %h %b",
                             idx, if4.data_o, if4.last_o, exp[idx], (idx == 3));
                end
                idx++;
            end
        end
        n_chk++;
        if (idx != 4 || if4.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_count: got %0d beats v=%b expected 4 beats v=0", idx, if4.valid_o);
        end
        if4.ready_i = 1'b1;
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp [4] = '{8'hEF, 8'hBE, 8'h00, 8'h00};
        @(negedge clk);
        if4.valid_i = 1'b1; if4.data_i = 32'h4433_2211; if4.ready_i = 1'b1;
        @(negedge clk);
        if4.valid_i = 1'b0;
        @(negedge clk); #1;
        n_chk++;
        if (if4.data_o !== 8'h22) begin
            n_fail++;
            $display("FAIL midrst_pre: got %h expected 22", if4.data_o);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (if4.valid_o !== 1'b0 || if4.ready_o !== 1'b0 || if4.data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_async: got v=%b r=%b d=%h expected 0 0 00",
                     if4.valid_o, if4.ready_o, if4.data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.valid_i = 1'b1; if4.data_i = 32'h0000_BEEF;
        #1;
        n_chk++;
        if (if4.ready_o !== 1'b1 || if4.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: got r=%b v=%b expected 1 0", if4.ready_o, if4.valid_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if4.valid_i = 1'b0;
            #1;
            n_chk++;
            if (if4.valid_o !== 1'b1 || if4.data_o !== exp[k] || if4.last_o !== (k == 3)) begin
                n_fail++;
                $display("FAIL midrst_beat%0d: got v=%b d=%h l=%b expected 1 %h %b",
                         k, if4.valid_o, if4.data_o, if4.last_o, exp[k], (k == 3));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ratio1();
        int sent = 0;
        int rcvd = 0;
        logic in_fire;
        for (int c = 0; c < 200 && rcvd < 16; c++) begin
            @(negedge clk);
            if1.valid_i = (sent < 16);
            if1.data_i  = 8'(sent + 1);
            if1.ready_i = 1'($urandom_range(0, 1));
            #1;
            in_fire = if1.valid_i && if1.ready_o;
            n_chk++;
            if (if1.ready_o !== (!if1.valid_o || if1.ready_i)) begin
                n_fail++;
                $display("FAIL r1_ready: got %b expected %b", if1.ready_o, (!if1.valid_o || if1.ready_i));
            end
            if (if1.valid_o && if1.ready_i) begin
                n_chk++;
                if (if1.data_o !== 8'(rcvd + 1) || if1.last_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL r1_beat%0d: got d=%h l=%b expected %h 1",
                             rcvd, if1.data_o, if1.last_o, 8'(rcvd + 1));
                end
                rcvd++;
            end
            if (in_fire) sent++;
        end
        n_chk++;
        if (rcvd != 16) begin
            n_fail++;
            $display("FAIL r1_count: got %0d words expected 16", rcvd);
        end
        @(negedge clk);
        if1.valid_i = 1'b0; if1.ready_i = 1'b1;
        @(negedge clk); #1;
        n_chk++;
        if (if1.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL r1_drain: got valid_o=%b expected 0", if1.valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_ready_toggle();
        test_reset_mid_word();
        test_ratio1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
